stream_fifo: RTL and testbench
==============================

// Module: stream_fifo
// PURPOSE
//   Parametrised synchronous FIFO with valid/ready handshakes on both sides.
//   Successor to the unchecked ring buffer: full/empty protection, occupancy
//   level, programmable almost-full/almost-empty flags, flush and sticky error flags.
//   Sits between systolic-array edge feeders and the controller, and buffers
//   operand/result words across rate mismatch.
// PARAMETERS
//   WIDTH     8   data word width in bits (>=1)
//   DEPTH     16  storage entries, any integer >=2 (no power-of-2 restriction)
//   AF_LEVEL  12  almost_full asserted when level >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  2   almost_empty asserted when level <= AE_LEVEL (0..DEPTH-1)
//   LVL_W     $clog2(DEPTH+1)  width of level output (derived, not overridden)
// PORTS
//   clk           in   1      clock; all logic on rising edge
//   rst           in   1      synchronous, active-high reset
//   flush         in   1      synchronous clear of contents (data RAM untouched)
//   in_valid      in   1      producer has a word on in_data
//   in_ready      out  1      FIFO can accept; push = in_valid & in_ready
//   in_data       in   WIDTH  write word
//   out_valid     out  1      out_data holds the oldest word
//   out_ready     in   1      consumer takes word; pop = out_valid & out_ready
//   out_data      out  WIDTH  read word, driven from a register
//   level         out  LVL_W  words accepted and not yet popped (0..DEPTH)
//   almost_full   out  1      level >= AF_LEVEL
//   almost_empty  out  1      level <= AE_LEVEL
//   ovf_err       out  1      sticky: in_valid seen while in_ready=0 and ERR_ON_FULL
//   udf_err       out  1      sticky: out_ready seen while out_valid=0
//   err_clr       in   1      clears ovf_err/udf_err at the next edge
// BEHAVIOUR
//   - Reset (rst=1 at edge): level=0, pointers=0, out_valid=0, out_data=0,
//     in_ready=1, almost_empty=1, almost_full=(AF_LEVEL==0? n/a)=0, errors=0.
//     rst overrides every other input, including a push/pop in the same cycle.
//   - flush=1 at edge: same as reset except the sticky error flags and RAM
//     contents are kept. A push/pop in the flush cycle is discarded.
//   - in_ready = (level < DEPTH). It is a registered function of level and
//     does NOT look at out_ready. When full, a same-cycle pop does not
//     allow a push. in_ready stays combinationally independent of in_valid.
//   - out_valid = (level != 0). out_data changes only on the edge after a pop,
//     or on the edge after a push into an empty FIFO. It is held stable while
//     out_valid=1 and out_ready=0.
//   - Latency: a word pushed at edge N into an empty FIFO shows out_valid=1
//     and out_data=word after edge N (1 cycle). There is no combinational
//     path from in_data to out_data.
//   - Ordering: strict FIFO. A word pushed is popped exactly once.
//   - Simultaneous push and pop (0<level<DEPTH): level is unchanged, both
//     happen. With level==1, out_data advances to the pushed word after the edge.
//   - level: +1 on push only, -1 on pop only, unchanged otherwise.
//     almost_full and almost_empty are derived from the post-edge level.
//   - Pointers wrap from DEPTH-1 to 0 explicitly (no modulo-2^n reliance).
//   - ovf_err is set when in_valid=1 and in_ready=0 at an edge.
//     udf_err is set when out_ready=1 and out_valid=0 at an edge.
//     Each stays set until err_clr or rst. If set and clear occur in the same
//     cycle, set wins. Neither flag alters the data path.
// TESTING
//   1 Reset: drive rst mid-stream with level=5 -> next cycle level=0,
//     out_valid=0, out_data=0, in_ready=1, almost_empty=1.
//   2 Latency/order: push 0x11,0x22,0x33 with out_ready=0, then out_ready=1
//     -> 0x11 is visible 1 cycle after its push; pops return 11,22,33;
//     level goes 1,2,3,2,1,0.
//   3 Full: push 16 words with out_ready=0 -> in_ready=0 at level=16 and
//     almost_full from level=12. A 17th in_valid plus a same-cycle pop ->
//     no push, level=15, ovf_err=1.
//   4 Wrap, DEPTH=5: stream 23 words 0..22 with random valid/ready
//     -> output sequence is exactly 0..22 and level never exceeds 5.
//   5 Simultaneous push+pop at level=1 (out_data=0xA0, push 0xA1)
//     -> level stays 1 and out_data=0xA1 after the edge.
//   6 Flush/errors: pop while empty -> udf_err=1. flush at level=4 ->
//     level=0 and udf_err stays 1. err_clr -> udf_err=0.

Source files
------------

// File: rtl/stream_fifo.sv
// Synchronous valid/ready FIFO with occupancy level, almost-full/empty
// flags, flush and sticky overflow/underflow error flags.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2,
  parameter bit ERR_ON_FULL = 1'b1,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LVL_W-1:0] level,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             ovf_err,
  output logic             udf_err,
  input  logic             err_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] L_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] L_AF = LVL_W'(AF_LEVEL);
  localparam logic [LVL_W-1:0] L_AE = LVL_W'(AE_LEVEL);
  localparam logic [LVL_W-1:0] L_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] L_ZERO = '0;
  localparam logic [PTR_W-1:0] P_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic [WIDTH-1:0] r_out_data;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_af;
  logic             r_ae;
  logic             r_ovf;
  logic             r_udf;

  logic             w_push;
  logic             w_pop;
  logic             w_wr;
  logic             w_ovf_set;
  logic             w_udf_set;
  logic [PTR_W-1:0] w_wptr_inc;
  logic [PTR_W-1:0] w_rptr_inc;
  logic [LVL_W-1:0] w_level_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = out_ready & r_out_valid;
  assign w_wr   = w_push & ~rst & ~flush;

  assign w_ovf_set = ERR_ON_FULL & in_valid & ~r_in_ready;
  assign w_udf_set = out_ready & ~r_out_valid;

  assign w_wptr_inc = (r_wptr == P_LAST) ? '0 : r_wptr + 1'b1;
  assign w_rptr_inc = (r_rptr == P_LAST) ? '0 : r_rptr + 1'b1;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  // out_data is a head register: at level 1 the slot after the head is
  // being written this cycle, so the new head comes straight from in_data.
  always_comb begin
    w_head_nxt = r_out_data;
    if (w_pop) begin
      if (r_level == L_ONE) begin
        if (w_push) begin
          w_head_nxt = in_data;
        end
      end else begin
        w_head_nxt = r_mem[w_rptr_inc];
      end
    end else if (w_push && (r_level == L_ZERO)) begin
      w_head_nxt = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_out_data  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_af        <= 1'b0;
      r_ae        <= 1'b1;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      if (flush) begin
        r_wptr      <= '0;
        r_rptr      <= '0;
        r_level     <= '0;
        r_out_data  <= '0;
        r_in_ready  <= 1'b1;
        r_out_valid <= 1'b0;
        r_af        <= 1'b0;
        r_ae        <= 1'b1;
      end else begin
        if (w_push) begin
          r_wptr <= w_wptr_inc;
        end
        if (w_pop) begin
          r_rptr <= w_rptr_inc;
        end
        r_level     <= w_level_nxt;
        r_out_data  <= w_head_nxt;
        r_in_ready  <= (w_level_nxt < L_FULL);
        r_out_valid <= (w_level_nxt != L_ZERO);
        r_af        <= (w_level_nxt >= L_AF);
        r_ae        <= (w_level_nxt <= L_AE);
      end
      r_ovf <= w_ovf_set | (r_ovf & ~err_clr);
      r_udf <= w_udf_set | (r_udf & ~err_clr);
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign level        = r_level;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign ovf_err      = r_ovf;
  assign udf_err      = r_udf;

endmodule

// File: tb/tb_stream_fifo.sv
// Testbench for stream_fifo: vector table, hand sequences and a random
// run checked against a queue-based reference model (DEPTH 16 and 5).
module tb_stream_fifo;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [4:0] level;
  logic       af, ae, ovf, udf, err_clr;

  logic       rst5, flush5, iv5, ir5, ov5, or5;
  logic [7:0] d5, od5;
  logic [2:0] level5;
  logic       af5, ae5, ovf5, udf5, ec5;

  stream_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .almost_full(af), .almost_empty(ae),
    .ovf_err(ovf), .udf_err(udf), .err_clr(err_clr)
  );

  stream_fifo #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
    .clk(clk), .rst(rst5), .flush(flush5),
    .in_valid(iv5), .in_ready(ir5), .in_data(d5),
    .out_valid(ov5), .out_ready(or5), .out_data(od5),
    .level(level5), .almost_full(af5), .almost_empty(ae5),
    .ovf_err(ovf5), .udf_err(udf5), .err_clr(ec5)
  );

  int n_pass = 0;
  int n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
  endtask

  // reference model: one queue per DUT, index 0 = DEPTH 16, 1 = DEPTH 5
  logic [7:0] q16[$];
  logic [7:0] q5[$];
  logic [7:0] pop5[$];
  bit m_ovf[2];
  bit m_udf[2];
  bit m_odz[2];

  task automatic model_step(input int w, input bit r, input bit f,
                            input bit iv, input logic [7:0] d,
                            input bit orr, input bit ec);
    int sz;
    int dep;
    bit so;
    bit su;
    sz = (w == 0) ? q16.size() : q5.size();
    dep = (w == 0) ? 16 : 5;
    if (r) begin
      if (w == 0) q16.delete(); else q5.delete();
      m_ovf[w] = 0;
      m_udf[w] = 0;
      m_odz[w] = 1;
      return;
    end
    so = iv && (sz >= dep);
    su = orr && (sz == 0);
    if (f) begin
      if (w == 0) q16.delete(); else q5.delete();
      m_odz[w] = 1;
    end else begin
      if (orr && sz > 0) begin
        if (w == 0) void'(q16.pop_front());
        else pop5.push_back(q5.pop_front());
      end
      if (iv && sz < dep) begin
        if (w == 0) q16.push_back(d); else q5.push_back(d);
        m_odz[w] = 0;
      end
    end
    if (so) m_ovf[w] = 1; else if (ec) m_ovf[w] = 0;
    if (su) m_udf[w] = 1; else if (ec) m_udf[w] = 0;
  endtask

  task automatic check_dut(input int w);
    int sz;
    int dep;
    int afl;
    int ael;
    logic [7:0] hd;
    string p;
    if (w == 0) begin
      sz = q16.size(); dep = 16; afl = 12; ael = 2; p = "d16";
      hd = (sz > 0) ? q16[0] : 8'h00;
      chk({p, ".level"}, level, sz);
      chk({p, ".out_valid"}, out_valid, sz > 0);
      chk({p, ".in_ready"}, in_ready, sz < dep);
      chk({p, ".almost_full"}, af, sz >= afl);
      chk({p, ".almost_empty"}, ae, sz <= ael);
      chk({p, ".ovf_err"}, ovf, m_ovf[0]);
      chk({p, ".udf_err"}, udf, m_udf[0]);
      if (sz > 0 || m_odz[0]) chk({p, ".out_data"}, out_data, hd);
    end else begin
      sz = q5.size(); dep = 5; afl = 4; ael = 1; p = "d5";
      hd = (sz > 0) ? q5[0] : 8'h00;
      chk({p, ".level"}, level5, sz);
      chk({p, ".out_valid"}, ov5, sz > 0);
      chk({p, ".in_ready"}, ir5, sz < dep);
      chk({p, ".almost_full"}, af5, sz >= afl);
      chk({p, ".almost_empty"}, ae5, sz <= ael);
      chk({p, ".ovf_err"}, ovf5, m_ovf[1]);
      chk({p, ".udf_err"}, udf5, m_udf[1]);
      if (sz > 0 || m_odz[1]) chk({p, ".out_data"}, od5, hd);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    model_step(0, rst, flush, in_valid, in_data, out_ready, err_clr);
    model_step(1, rst5, flush5, iv5, d5, or5, ec5);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  typedef struct {
    bit r; bit f; bit iv; logic [7:0] d; bit orr; bit ec;
    int lvl; bit ov; bit cod; logic [7:0] od;
    bit ir; bit af; bit ae; bit ovf; bit udf;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit pushed;
    int nw;
    int cyc;

    // r f iv d orr ec | lvl ov cod od ir af ae ovf udf
    tbl.push_back('{1,0,0,8'h00,0,0, 0,0,1,8'h00,1,0,1,0,0});
    tbl.push_back('{0,0,1,8'h11,0,0, 1,1,1,8'h11,1,0,1,0,0});
    tbl.push_back('{0,0,1,8'h22,0,0, 2,1,1,8'h11,1,0,1,0,0});
    tbl.push_back('{0,0,1,8'h33,0,0, 3,1,1,8'h11,1,0,0,0,0});
    tbl.push_back('{0,0,0,8'h00,1,0, 2,1,1,8'h22,1,0,1,0,0});
    tbl.push_back('{0,0,0,8'h00,1,0, 1,1,1,8'h33,1,0,1,0,0});
    tbl.push_back('{0,0,0,8'h00,1,0, 0,0,0,8'h00,1,0,1,0,0});
    tbl.push_back('{0,0,1,8'hA0,0,0, 1,1,1,8'hA0,1,0,1,0,0});
    tbl.push_back('{0,0,1,8'hA1,1,0, 1,1,1,8'hA1,1,0,1,0,0});
    tbl.push_back('{0,0,0,8'h00,1,0, 0,0,0,8'h00,1,0,1,0,0});
    tbl.push_back('{0,0,0,8'h00,1,0, 0,0,0,8'h00,1,0,1,0,1});
    tbl.push_back('{0,0,1,8'h01,0,0, 1,1,1,8'h01,1,0,1,0,1});
    tbl.push_back('{0,0,1,8'h02,0,0, 2,1,1,8'h01,1,0,1,0,1});
    tbl.push_back('{0,0,1,8'h03,0,0, 3,1,1,8'h01,1,0,0,0,1});
    tbl.push_back('{0,0,1,8'h04,0,0, 4,1,1,8'h01,1,0,0,0,1});
    tbl.push_back('{0,1,1,8'h55,1,0, 0,0,1,8'h00,1,0,1,0,1});
    tbl.push_back('{0,0,0,8'h00,0,1, 0,0,1,8'h00,1,0,1,0,0});
    tbl.push_back('{0,0,0,8'h00,1,1, 0,0,1,8'h00,1,0,1,0,1});
    tbl.push_back('{0,0,0,8'h00,0,1, 0,0,1,8'h00,1,0,1,0,0});
    tbl.push_back('{0,0,1,8'h61,0,0, 1,1,1,8'h61,1,0,1,0,0});
    tbl.push_back('{0,0,1,8'h62,0,0, 2,1,1,8'h61,1,0,1,0,0});
    tbl.push_back('{0,0,1,8'h63,0,0, 3,1,1,8'h61,1,0,0,0,0});
    tbl.push_back('{0,0,1,8'h64,0,0, 4,1,1,8'h61,1,0,0,0,0});
    tbl.push_back('{0,0,1,8'h65,0,0, 5,1,1,8'h61,1,0,0,0,0});
    tbl.push_back('{1,0,1,8'h77,1,0, 0,0,1,8'h00,1,0,1,0,0});

    rst = 1; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
    err_clr = 0;
    rst5 = 1; flush5 = 0; iv5 = 0; d5 = 0; or5 = 0; ec5 = 0;
    tick;
    rst = 0; rst5 = 0;

    foreach (tbl[i]) begin
      rst = tbl[i].r; flush = tbl[i].f; in_valid = tbl[i].iv;
      in_data = tbl[i].d; out_ready = tbl[i].orr; err_clr = tbl[i].ec;
      tick;
      chk($sformatf("vec%0d.level", i), level, tbl[i].lvl);
      chk($sformatf("vec%0d.out_valid", i), out_valid, tbl[i].ov);
      if (tbl[i].cod) chk($sformatf("vec%0d.out_data", i), out_data, tbl[i].od);
      chk($sformatf("vec%0d.in_ready", i), in_ready, tbl[i].ir);
      chk($sformatf("vec%0d.almost_full", i), af, tbl[i].af);
      chk($sformatf("vec%0d.almost_empty", i), ae, tbl[i].ae);
      chk($sformatf("vec%0d.ovf_err", i), ovf, tbl[i].ovf);
      chk($sformatf("vec%0d.udf_err", i), udf, tbl[i].udf);
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 0; err_clr = 0;

    // fill to full, then a blocked push alongside a pop
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1; in_data = 8'(8'h80 + i); out_ready = 0;
      tick;
      chk("full.level", level, i);
      chk("full.almost_full", af, i >= 12);
      chk("full.in_ready", in_ready, i < 16);
    end
    in_valid = 1; in_data = 8'hEE; out_ready = 1;
    tick;
    chk("full.level_after", level, 15);
    chk("full.ovf_err", ovf, 1);
    chk("full.head", out_data, 8'h82);
    in_valid = 0;
    for (int i = 0; i < 15; i++) tick;
    out_ready = 0; err_clr = 1;
    tick;
    chk("full.ovf_clr", ovf, 0);
    err_clr = 0;

    // DEPTH 5 wrap stream of 0..22 with random handshakes
    pop5.delete();
    nw = 0;
    cyc = 0;
    while (pop5.size() < 23 && cyc < 2000) begin
      iv5 = (nw < 23) && ($urandom_range(0, 3) != 0);
      d5 = 8'(nw);
      or5 = ($urandom_range(0, 2) != 0);
      pushed = iv5 && (q5.size() < 5);
      tick;
      if (pushed) nw++;
      chk("wrap.level_max", level5 <= 3'd5, 1);
      cyc++;
    end
    iv5 = 0; or5 = 0;
    chk("wrap.count", pop5.size(), 23);
    foreach (pop5[i]) chk("wrap.order", pop5[i], i);

    // random traffic on DEPTH 16
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 49) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      out_ready = (i < 200) ? ($urandom_range(0, 2) == 0)
                            : ($urandom_range(0, 3) != 0);
      err_clr = ($urandom_range(0, 7) == 0);
      tick;
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 0; err_clr = 0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
